// File: rtl/model_standard_fnn_pkg.sv
// Shared types for the standard FNN controller sequencer.
package model_standard_fnn_pkg;

    typedef enum logic [1:0] {
        OP_WX = 2'd0,
        OP_KR = 2'd1,
        OP_UH = 2'd2,
        OP_B  = 2'd3
    } fnn_op_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_MAC_X,
        ST_MAC_R,
        ST_MAC_H,
        ST_BIAS,
        ST_ACT,
        ST_WRITE,
        ST_DONE
    } fnn_sched_state_t;

endpackage

// File: rtl/model_fnn_index_counter.sv
// Wrapping index counter: advances on inc_i, returns to 0 after reaching limit_i.
module model_fnn_index_counter #(
    parameter int unsigned WIDTH = 64
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [WIDTH-1:0] limit_i,
    input  logic             inc_i,
    input  logic             clr_i,
    output logic [WIDTH-1:0] count_o,
    output logic             last_o
);

    logic [WIDTH-1:0] count_q, count_d;

    assign last_o  = (count_q == limit_i);
    assign count_o = count_q;

    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (inc_i) begin
            count_d = last_o ? '0 : count_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/model_standard_fnn_scheduler.sv
// Row sequencer for h(t)=act(W*x + sum K_i*r_i + U*h(t-1) + b) over a shared MAC and activation unit.
module model_standard_fnn_scheduler
    import model_standard_fnn_pkg::*;
#(
    parameter int unsigned DATA_SIZE    = 64,
    parameter int unsigned CONTROL_SIZE = 64,
    parameter int unsigned X            = 64,
    parameter int unsigned R            = 64,
    parameter int unsigned W            = 64,
    parameter int unsigned L            = 64
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic                    START,
    output logic                    BUSY,
    output logic                    READY,
    output logic                    H_SWAP,
    output logic                    MAC_VALID,
    input  logic                    MAC_READY,
    output logic                    MAC_CLR,
    output logic [1:0]              MAC_OP,
    output logic [CONTROL_SIZE-1:0] ROW_IDX,
    output logic [CONTROL_SIZE-1:0] HEAD_IDX,
    output logic [CONTROL_SIZE-1:0] COL_IDX,
    output logic                    ACT_VALID,
    input  logic                    ACT_READY,
    output logic                    H_WE
);

    localparam logic [CONTROL_SIZE-1:0] X_LAST = CONTROL_SIZE'(X - 1);
    localparam logic [CONTROL_SIZE-1:0] R_LAST = CONTROL_SIZE'(R - 1);
    localparam logic [CONTROL_SIZE-1:0] W_LAST = CONTROL_SIZE'(W - 1);
    localparam logic [CONTROL_SIZE-1:0] L_LAST = CONTROL_SIZE'(L - 1);

    // Datapath width lives outside this block; referenced here only to keep the parameter set uniform.
    if (DATA_SIZE == 0) begin : g_no_datapath
    end

    fnn_sched_state_t state_q, state_d;
    fnn_op_t          mac_op;
    logic             mac_valid, act_valid, h_we, done;
    logic             ctr_clr, col_inc, head_inc, row_inc;
    logic             col_last, head_last, row_last;
    logic [CONTROL_SIZE-1:0] col_limit, col_cnt, head_cnt, row_cnt;

    always_comb begin
        state_d   = state_q;
        mac_valid = 1'b0;
        act_valid = 1'b0;
        h_we      = 1'b0;
        done      = 1'b0;
        mac_op    = OP_WX;
        col_limit = '0;
        col_inc   = 1'b0;
        head_inc  = 1'b0;
        row_inc   = 1'b0;
        ctr_clr   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                ctr_clr = 1'b1;
                if (START) state_d = ST_MAC_X;
            end
            ST_MAC_X: begin
                mac_valid = 1'b1;
                col_limit = X_LAST;
                col_inc   = MAC_READY;
                if (MAC_READY && col_last) state_d = ST_MAC_R;
            end
            ST_MAC_R: begin
                mac_valid = 1'b1;
                mac_op    = OP_KR;
                col_limit = W_LAST;
                col_inc   = MAC_READY;
                head_inc  = MAC_READY && col_last;
                if (MAC_READY && col_last && head_last) state_d = ST_MAC_H;
            end
            ST_MAC_H: begin
                mac_valid = 1'b1;
                mac_op    = OP_UH;
                col_limit = L_LAST;
                col_inc   = MAC_READY;
                if (MAC_READY && col_last) state_d = ST_BIAS;
            end
            ST_BIAS: begin
                mac_valid = 1'b1;
                mac_op    = OP_B;
                if (MAC_READY) state_d = ST_ACT;
            end
            ST_ACT: begin
                act_valid = 1'b1;
                if (ACT_READY) state_d = ST_WRITE;
            end
            ST_WRITE: begin
                h_we    = 1'b1;
                row_inc = 1'b1;
                state_d = row_last ? ST_DONE : ST_MAC_X;
            end
            ST_DONE: begin
                done    = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // One column counter is shared by j, k and m; its limit follows the active term.
    model_fnn_index_counter #(.WIDTH(CONTROL_SIZE)) u_col_ctr (
        .clk_i   (CLK),
        .rst_ni  (RST),
        .limit_i (col_limit),
        .inc_i   (col_inc),
        .clr_i   (ctr_clr),
        .count_o (col_cnt),
        .last_o  (col_last)
    );

    model_fnn_index_counter #(.WIDTH(CONTROL_SIZE)) u_head_ctr (
        .clk_i   (CLK),
        .rst_ni  (RST),
        .limit_i (R_LAST),
        .inc_i   (head_inc),
        .clr_i   (ctr_clr),
        .count_o (head_cnt),
        .last_o  (head_last)
    );

    model_fnn_index_counter #(.WIDTH(CONTROL_SIZE)) u_row_ctr (
        .clk_i   (CLK),
        .rst_ni  (RST),
        .limit_i (L_LAST),
        .inc_i   (row_inc),
        .clr_i   (ctr_clr),
        .count_o (row_cnt),
        .last_o  (row_last)
    );

    assign BUSY      = (state_q != ST_IDLE);
    assign READY     = done;
    assign H_SWAP    = done;
    assign MAC_VALID = mac_valid;
    assign MAC_OP    = mac_op;
    assign MAC_CLR   = (state_q == ST_MAC_X) && (col_cnt == '0);
    assign ACT_VALID = act_valid;
    assign H_WE      = h_we;
    assign ROW_IDX   = row_cnt;
    assign HEAD_IDX  = (state_q == ST_MAC_R) ? head_cnt : '0;
    assign COL_IDX   = (state_q inside {ST_MAC_X, ST_MAC_R, ST_MAC_H}) ? col_cnt : '0;

endmodule

// File: tb/tb_model_standard_fnn_scheduler.sv
// Directed bench for the FNN sequencer with X=2 R=2 W=2 L=3.
module tb_model_standard_fnn_scheduler;

    localparam int unsigned CS = 16;

    logic          CLK = 1'b0;
    logic          RST = 1'b0;
    logic          START = 1'b0;
    logic          MAC_READY = 1'b1;
    logic          ACT_READY = 1'b1;
    logic          BUSY, READY, H_SWAP, MAC_VALID, MAC_CLR, ACT_VALID, H_WE;
    logic [1:0]    MAC_OP;
    logic [CS-1:0] ROW_IDX, HEAD_IDX, COL_IDX;

    int checks = 0;
    int failures = 0;

    int            ready_cnt = 0;
    int            swap_cnt = 0;
    int            overlap_cnt = 0;
    logic [CS-1:0] we_rows[$];
    logic [5:0]    beats[$];
    logic          clrs[$];

    logic [9+3*CS-1:0] outs;
    assign outs = {BUSY, READY, H_SWAP, MAC_VALID, MAC_CLR, MAC_OP, ACT_VALID, H_WE,
                   ROW_IDX, HEAD_IDX, COL_IDX};

    model_standard_fnn_scheduler #(
        .DATA_SIZE    (64),
        .CONTROL_SIZE (CS),
        .X            (2),
        .R            (2),
        .W            (2),
        .L            (3)
    ) dut (
        .CLK       (CLK),
        .RST       (RST),
        .START     (START),
        .BUSY      (BUSY),
        .READY     (READY),
        .H_SWAP    (H_SWAP),
        .MAC_VALID (MAC_VALID),
        .MAC_READY (MAC_READY),
        .MAC_CLR   (MAC_CLR),
        .MAC_OP    (MAC_OP),
        .ROW_IDX   (ROW_IDX),
        .HEAD_IDX  (HEAD_IDX),
        .COL_IDX   (COL_IDX),
        .ACT_VALID (ACT_VALID),
        .ACT_READY (ACT_READY),
        .H_WE      (H_WE)
    );

    always #5 CLK = ~CLK;

    always @(negedge CLK) begin
        if (RST) begin
            if (READY) ready_cnt++;
            if (H_SWAP) swap_cnt++;
            if (MAC_VALID && ACT_VALID) overlap_cnt++;
            if (H_WE) we_rows.push_back(ROW_IDX);
            if (MAC_VALID && MAC_READY && ROW_IDX == '0) begin
                beats.push_back({MAC_OP, HEAD_IDX[1:0], COL_IDX[1:0]});
                clrs.push_back(MAC_CLR);
            end
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // mode: 0 plain, 1 MAC stall on beat (1,1,0), 2 slow activation, 3 stray START pulse, 4 stop at row 1 MAC_H
    task automatic run_step(input int mode, output int lat, output int frozen, output bit aborted);
        int stall_left = 5;
        int act_cnt = 0;
        bit pulsed = 1'b0;
        frozen  = 0;
        aborted = 1'b0;
        if (mode == 2) ACT_READY = 1'b0;
        START = 1'b1;
        tick();
        START = 1'b0;
        lat = 0;
        while (!READY && lat < 300 && !aborted) begin
            tick();
            lat++;
            if (mode == 1) begin
                if (MAC_VALID && MAC_OP == 2'd1 && HEAD_IDX == 1 && COL_IDX == 0 && ROW_IDX == 0)
                    frozen++;
                if (MAC_VALID && MAC_OP == 2'd1 && HEAD_IDX == 1 && COL_IDX == 0 && stall_left > 0) begin
                    MAC_READY = 1'b0;
                    stall_left--;
                end else begin
                    MAC_READY = 1'b1;
                end
            end
            if (mode == 2) begin
                if (ACT_VALID) begin
                    ACT_READY = (act_cnt >= 4);
                    act_cnt++;
                end else begin
                    ACT_READY = 1'b0;
                    act_cnt = 0;
                end
            end
            if (mode == 3) begin
                START = 1'b0;
                if (!pulsed && MAC_VALID && MAC_OP == 2'd1) begin
                    START = 1'b1;
                    pulsed = 1'b1;
                end
            end
            if (mode == 4 && MAC_VALID && MAC_OP == 2'd2 && ROW_IDX == 1)
                aborted = 1'b1;
        end
        MAC_READY = 1'b1;
        ACT_READY = 1'b1;
        START = 1'b0;
    endtask

    logic [5:0] exp_beats [10];
    int lat, frozen, r0, s0, w0, b0;
    bit aborted;

    initial begin
        exp_beats = '{6'b00_00_00, 6'b00_00_01, 6'b01_00_00, 6'b01_00_01, 6'b01_01_00,
                      6'b01_01_01, 6'b10_00_00, 6'b10_00_01, 6'b10_00_10, 6'b11_00_00};

        repeat (3) tick();
        check("reset_outputs", 64'(outs), 64'd0);
        RST = 1'b1;
        tick();
        check("idle_outputs", 64'(outs), 64'd0);

        // Plain step
        r0 = ready_cnt; s0 = swap_cnt; w0 = we_rows.size(); b0 = beats.size();
        run_step(0, lat, frozen, aborted);
        check("plain_latency", 64'(lat), 64'd36);
        check("plain_hswap_with_ready", 64'(H_SWAP), 64'd1);
        tick();
        check("plain_idle_after_done", 64'(BUSY), 64'd0);
        check("plain_ready_count", 64'(ready_cnt - r0), 64'd1);
        check("plain_swap_count", 64'(swap_cnt - s0), 64'd1);
        check("plain_hwe_count", 64'(we_rows.size() - w0), 64'd3);
        for (int k = 0; k < 3; k++)
            if (w0 + k < we_rows.size())
                check($sformatf("plain_hwe_row%0d", k), 64'(we_rows[w0 + k]), 64'(k));
        check("plain_row0_beats", 64'(beats.size() - b0), 64'd10);
        for (int k = 0; k < 10; k++)
            if (b0 + k < beats.size()) begin
                check($sformatf("beat%0d", k), 64'(beats[b0 + k]), 64'(exp_beats[k]));
                check($sformatf("clr%0d", k), 64'(clrs[b0 + k]), (k == 0) ? 64'd1 : 64'd0);
            end

        // MAC back-pressure on beat (1,1,0)
        tick();
        run_step(1, lat, frozen, aborted);
        check("stall_latency", 64'(lat), 64'd41);
        check("stall_frozen_cycles", 64'(frozen), 64'd6);
        tick();

        // Activation delayed 4 cycles per row
        tick();
        run_step(2, lat, frozen, aborted);
        check("act_latency", 64'(lat), 64'd48);
        check("act_no_overlap", 64'(overlap_cnt), 64'd0);
        tick();

        // START during MAC_R and during DONE
        tick();
        r0 = ready_cnt;
        run_step(3, lat, frozen, aborted);
        check("ignore_latency", 64'(lat), 64'd36);
        START = 1'b1;
        tick();
        START = 1'b0;
        check("ignore_done_start", 64'(BUSY), 64'd0);
        repeat (5) tick();
        check("ignore_still_idle", 64'(BUSY), 64'd0);
        check("ignore_ready_count", 64'(ready_cnt - r0), 64'd1);

        // Abort mid-step by reset
        s0 = swap_cnt;
        run_step(4, lat, frozen, aborted);
        check("abort_reached_row1_mac_h", 64'(aborted), 64'd1);
        RST = 1'b0;
        #1;
        check("abort_async_outputs", 64'(outs), 64'd0);
        tick();
        check("abort_next_cycle_outputs", 64'(outs), 64'd0);
        RST = 1'b1;
        tick();
        check("abort_no_swap", 64'(swap_cnt - s0), 64'd0);
        run_step(0, lat, frozen, aborted);
        check("restart_latency", 64'(lat), 64'd36);
        check("restart_hswap", 64'(H_SWAP), 64'd1);
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
